alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered ALU for the RISC-V datapath. It generalises the fixed 8-bit ripple ALU to WIDTH bits.
- Adds a 4-bit RISC-V-style opcode set with shifts and compares, plus status flags, valid/ready handshakes on input and output, and an optional iterative multiplier.
- Sits between the register-file read stage and writeback. It is the first ALU in the design that can stall the pipeline.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- carry_in  in  1  carry into ADD only
- alu_op  in  4  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- carry_out  out  1  carry/no-borrow flag
- overflow  out  1  signed overflow flag
- zero  out  1  result == 0
- err  out  1  illegal opcode

Behaviour:
- Reset state (asynchronous, when rst_n low):
  - state=IDLE; result=0; carry_out=0; overflow=0; zero=0; err=0; out_valid=0; iteration counter=0.
  - in_ready=1 once rst_n is high.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD (a+b+carry_in), 0011 XOR.
  - 0100 SLL, 0101 SRL, 0111 SRA; shift amount is b[SHW-1:0].
  - 0110 SUB (a+~b+1; carry_in ignored).
  - 1000 SLT (signed), 1001 SLTU; result 1 or 0, zero-extended.
  - 1010 MUL (low WIDTH bits of the product).
  - All other codes are illegal.
- Flags:
  - carry_out = bit WIDTH of the ADD/SUB sum. For SUB, 1 means no borrow.
  - overflow = signed overflow of the ADD/SUB sum.
  - carry_out and overflow are 0 for every other opcode.
  - zero = (result==0) for all legal opcodes.
  - Illegal opcode: result=0, err=1, zero=0, one-cycle path.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, capture operands.
    - Non-MUL opcode: go to DONE, with result and flags registered on the same edge.
    - MUL: go to MUL, clear the accumulator, counter=WIDTH-1.
  - MUL: one shift-add step per cycle: if multiplier LSB is 1, add the multiplicand into the accumulator; then shift the multiplicand left and the multiplier right.
    - in_ready=0 throughout.
    - When counter==0, register the result and flags and go to DONE.
  - DONE: out_valid=1. result and flags are held stable until out_ready.
    - On out_ready, out_valid drops the next cycle unless a new op is accepted.
    - in_ready = out_ready in DONE, giving back-to-back issue. A simultaneous accept enters DONE again (non-MUL) or MUL.
- Latency:
  - Non-MUL: out_valid is high in the cycle after the accept edge.
  - MUL: out_valid rises WIDTH+1 cycles after the accept edge.
  - Throughput is 1 op/cycle when out_ready is held high.
- Input side: no input is sampled unless in_valid && in_ready. in_valid while in_ready=0 is ignored; the source must hold its data.
- Reset mid-operation: the MUL in progress is abandoned immediately. No partial result is ever presented.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL is implemented as above.
- Undefined:
  - 1010 is treated as an illegal opcode: result=0, err=1, single-cycle latency.
  - The MUL state, counter and accumulator are not synthesised.
  - in_ready depends only on the IDLE/DONE state and out_ready.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (ALU_AND … ALU_MUL);
  - the state enum {IDLE, MUL, DONE};
  - a flags struct {carry, overflow, zero, err}.
- One sub-module, alu_comb, contains the purely combinational single-cycle datapath: logic, add/sub, shifts, compares and flags, for WIDTH bits.
- alu_seq owns the FSM, handshake, iterative multiplier and output registers.

Test Plan:
- WIDTH=32, ADD a=0xFFFFFFFF, b=1, carry_in=0 → result 0x00000000, zero=1, carry_out=1, overflow=0, out_valid one cycle after accept. Then ADD 0x7FFFFFFF+1 → 0x80000000, overflow=1.
- SUB 5−7 → 0xFFFFFFFE, carry_out=0, overflow=0. SLT a=0xFFFFFFFB (−5), b=3 → 1. SLTU on the same operands → 0. SRA 0x80000000 by 4 → 0xF8000000.
- MUL 0x00010003 × 0x00000005 (ALU_SEQ_MUL_EN defined):
  - result 0x0005000F;
  - in_ready=0 for 32 cycles;
  - out_valid 33 cycles after accept.
  - Without the macro: result 0, err=1, after 1 cycle.
- Back-pressure: hold out_ready=0 for 3 cycles after a result → result and flags stable, in_ready=0, and a new in_valid is not accepted. Then raise out_ready with a new op presented → accepted on the same edge.
- Illegal opcode 1111 → result 0, err=1, zero=0, carry_out=0.
- Deassert rst_n during cycle 10 of a MUL → out_valid=0 and result=0 immediately. After release, in_ready=1, and the next ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, FSM state type and flag bundle for the
//               sequential ALU (alu_seq) and its combinational datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_MUL  = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic err;
   } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Operand/result handshake bundle between the register-read
//               stage (master) and the sequential ALU (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic [3:0]       alu_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;
   logic             err;

   modport master (
      output in_valid, a, b, carry_in, alu_op, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow, zero, err
   );

   modport slave (
      input  in_valid, a, b, carry_in, alu_op, out_ready,
      output in_ready, out_valid, result, carry_out, overflow, zero, err
   );
endinterface
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Single-cycle combinational ALU datapath: logic ops, add/sub,
//               shifts, compares and status flags for WIDTH-bit operands.
//               MUL is not handled here; the sequencer owns it, so from this
//               block's point of view 1010 is reported as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry_in,
   input  logic [3:0]       i_alu_op,
   output logic [WIDTH-1:0] o_result,
   output alu_flags_t       o_flags
);
   localparam int SHW = $clog2(WIDTH);

   logic             w_is_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;
   logic [WIDTH:0]   w_sum;
   logic             w_add_ovf;
   logic [SHW-1:0]   w_shamt;

   // SUB reuses the adder as a + ~b + 1, so carry_out=1 means no borrow
   assign w_is_sub  = (i_alu_op == ALU_SUB);
   assign w_b_eff   = w_is_sub ? ~i_b : i_b;
   assign w_cin_eff = w_is_sub ? 1'b1 : i_carry_in;
   assign w_sum     = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};
   assign w_add_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
   assign w_shamt   = i_b[SHW-1:0];

   // Opcode decode; carry/overflow only meaningful for ADD/SUB
   always_comb begin
      o_result = '0;
      o_flags  = '0;
      case (i_alu_op)
         ALU_AND:  o_result = i_a & i_b;
         ALU_OR:   o_result = i_a | i_b;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_ADD,
         ALU_SUB: begin
            o_result         = w_sum[WIDTH-1:0];
            o_flags.carry    = w_sum[WIDTH];
            o_flags.overflow = w_add_ovf;
         end
         ALU_SLL:  o_result = i_a << w_shamt;
         ALU_SRL:  o_result = i_a >> w_shamt;
         ALU_SRA:  o_result = WIDTH'($signed(i_a) >>> w_shamt);
         ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
         default:  o_flags.err = 1'b1;
      endcase
      o_flags.zero = ~o_flags.err & (o_result == '0);
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered WIDTH-bit ALU with valid/ready handshakes on both
//               sides. Single-cycle ops complete through alu_comb; MUL runs
//               an iterative shift-add multiplier taking WIDTH steps.
//               Build option: define ALU_SEQ_MUL_EN to include the
//               multiplier; otherwise opcode 1010 is reported as illegal.
//               WIDTH must be >= 4 and a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_result;
   alu_flags_t       r_flags;
   logic [WIDTH-1:0] w_comb_result;
   alu_flags_t       w_comb_flags;
   logic             w_accept;
   logic             w_start_mul;
   logic             w_load_comb;

   alu_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .i_a        (bus.a),
      .i_b        (bus.b),
      .i_carry_in (bus.carry_in),
      .i_alu_op   (bus.alu_op),
      .o_result   (w_comb_result),
      .o_flags    (w_comb_flags)
   );

   // DONE frees up in the same cycle the consumer takes the result
   assign bus.in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
   assign w_accept     = bus.in_valid && bus.in_ready;

`ifdef ALU_SEQ_MUL_EN
   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             w_mul_last;
   alu_flags_t       w_mul_flags;

   assign w_start_mul = w_accept && (bus.alu_op == ALU_MUL);
   assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_last  = (r_state == MUL) && (r_cnt == '0);

   // Product never sets carry/overflow; only zero is derived
   always_comb begin
      w_mul_flags      = '0;
      w_mul_flags.zero = (w_acc_nxt == '0);
   end

   // Shift-add multiplier: one partial product per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (w_start_mul) begin
         r_mcand  <= bus.a;
         r_mplier <= bus.b;
         r_acc    <= '0;
         r_cnt    <= SHW'(WIDTH - 1);
      end else if (r_state == MUL) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - SHW'(1);
      end
   end
`else
   assign w_start_mul = 1'b0;
`endif

   // Next-state decode; accept takes priority over returning to IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_load_comb = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (w_accept) begin
               if (w_start_mul) begin
                  w_state_nxt = MUL;
               end else begin
                  w_state_nxt = DONE;
                  w_load_comb = 1'b1;
               end
            end else if ((r_state == DONE) && bus.out_ready) begin
               w_state_nxt = IDLE;
            end
         end
`ifdef ALU_SEQ_MUL_EN
         MUL: begin
            if (r_cnt == '0) begin
               w_state_nxt = DONE;
            end
         end
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and output registers; result only changes when a new one is ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_comb) begin
            r_result <= w_comb_result;
            r_flags  <= w_comb_flags;
         end
`ifdef ALU_SEQ_MUL_EN
         else if (w_mul_last) begin
            r_result <= w_acc_nxt;
            r_flags  <= w_mul_flags;
         end
`endif
      end
   end

   assign bus.out_valid = (r_state == DONE);
   assign bus.result    = r_result;
   assign bus.carry_out = r_flags.carry;
   assign bus.overflow  = r_flags.overflow;
   assign bus.zero      = r_flags.zero;
   assign bus.err       = r_flags.err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (WIDTH=32) with a
//               reference model and an output scoreboard. Honours
//               ALU_SEQ_MUL_EN for the MUL expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
   import alu_pkg::*;

   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
      logic        e;
   } exp_t;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   time  t_acc;
   time  t0;

   alu_seq_if #(.WIDTH(32)) bus ();

   alu_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference model: plain integer arithmetic on the opcode definitions
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] x,
                                  input logic [31:0] y, input logic ci);
      exp_t        r;
      longint      sx, sy, s;
      logic [63:0] u;
      r  = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (op)
         ALU_AND: r.res = x & y;
         ALU_OR:  r.res = x | y;
         ALU_XOR: r.res = x ^ y;
         ALU_ADD: begin
            u     = {32'b0, x} + {32'b0, y} + {63'b0, ci};
            r.res = u[31:0];
            r.c   = u[32];
            s     = sx + sy + longint'(ci);
            r.v   = (s > SMAX) || (s < SMIN);
         end
         ALU_SUB: begin
            r.res = x - y;
            r.c   = (x >= y);
            s     = sx - sy;
            r.v   = (s > SMAX) || (s < SMIN);
         end
         ALU_SLL:  r.res = x << y[4:0];
         ALU_SRL:  r.res = x >> y[4:0];
         ALU_SRA:  r.res = 32'(sx >>> y[4:0]);
         ALU_SLT:  r.res = (sx < sy) ? 32'd1 : 32'd0;
         ALU_SLTU: r.res = (x < y) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MUL_EN
         ALU_MUL: begin
            u     = {32'b0, x} * {32'b0, y};
            r.res = u[31:0];
         end
`endif
         default: r.e = 1'b1;
      endcase
      if (!r.e) r.z = (r.res == 32'd0);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, want);
      end
   endtask

   // Scoreboard: every completed handshake must match the model, and a
   // stalled result must not move
   logic held = 1'b0;
   exp_t snap;
   always @(negedge clk) begin
      exp_t cur;
      exp_t e;
      #2;
      cur = {bus.result, bus.carry_out, bus.overflow, bus.zero, bus.err};
      if (!rst_n || !bus.out_valid) begin
         held = 1'b0;
      end else begin
         if (held) begin
            total++;
            if (cur !== snap) begin
               bad++;
               $display("FAIL hold_stable: got %h, want %h", cur, snap);
            end
         end
         if (bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL spurious_result: got %h, want no result", cur);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  bad++;
                  $display("FAIL model_cmp: got res=%h c=%b v=%b z=%b e=%b, want res=%h c=%b v=%b z=%b e=%b",
                           cur.res, cur.c, cur.v, cur.z, cur.e, e.res, e.c, e.v, e.z, e.e);
               end
            end
            held = 1'b0;
         end else begin
            held = 1'b1;
            snap = cur;
         end
      end
   end

   // Present one op from a falling edge; returns just after its accept edge
   task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic ordy);
      @(negedge clk);
      bus.out_ready = ordy;
      bus.alu_op    = op;
      bus.a         = x;
      bus.b         = y;
      bus.carry_in  = ci;
      bus.in_valid  = 1'b1;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (bus.in_ready) begin
            exp_q.push_back(model(op, x, y, ci));
            @(posedge clk);
            t_acc = $time;
            return;
         end
         @(negedge clk);
      end
      chk("accept_timeout", 64'd0, 64'd1);
   endtask

   // Count cycles after the accept edge until out_valid; also count busy cycles
   task automatic wait_result(input int want_lat, input int want_busy, input string nm);
      int k;
      int busy;
      k    = 0;
      busy = 0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int n = 0; n < 200; n++) begin
         #1;
         k++;
         if (bus.out_valid) break;
         if (!bus.in_ready) busy++;
         @(negedge clk);
      end
      chk({nm, "_lat"}, 64'(k), 64'(want_lat));
      chk({nm, "_busy"}, 64'(busy), 64'(want_busy));
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.carry_in  = 1'b0;
      bus.alu_op    = 4'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_flags", 64'({bus.carry_out, bus.overflow, bus.zero, bus.err}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // ADD wrap to zero with carry
      issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
      wait_result(1, 0, "add_wrap");
      chk("add_wrap_res", 64'(bus.result), 64'h0);
      chk("add_wrap_flags", 64'({bus.carry_out, bus.overflow, bus.zero, bus.err}), 64'b1010);

      // ADD signed overflow
      issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
      wait_result(1, 0, "add_ovf");
      chk("add_ovf_res", 64'(bus.result), 64'h8000_0000);
      chk("add_ovf_v", 64'(bus.overflow), 64'd1);

      // SUB with borrow
      issue(ALU_SUB, 32'd5, 32'd7, 1'b1, 1'b1);
      wait_result(1, 0, "sub");
      chk("sub_res", 64'(bus.result), 64'hFFFF_FFFE);
      chk("sub_cv", 64'({bus.carry_out, bus.overflow}), 64'b00);

      issue(ALU_SLT, 32'hFFFF_FFFB, 32'd3, 1'b0, 1'b1);
      wait_result(1, 0, "slt");
      chk("slt_res", 64'(bus.result), 64'd1);

      issue(ALU_SLTU, 32'hFFFF_FFFB, 32'd3, 1'b0, 1'b1);
      wait_result(1, 0, "sltu");
      chk("sltu_res", 64'(bus.result), 64'd0);

      issue(ALU_SRA, 32'h8000_0000, 32'd4, 1'b0, 1'b1);
      wait_result(1, 0, "sra");
      chk("sra_res", 64'(bus.result), 64'hF800_0000);

      // MUL, or illegal when the multiplier is not built
      issue(ALU_MUL, 32'h0001_0003, 32'h0000_0005, 1'b0, 1'b1);
`ifdef ALU_SEQ_MUL_EN
      wait_result(33, 32, "mul");
      chk("mul_res", 64'(bus.result), 64'h0005_000F);
      chk("mul_err", 64'(bus.err), 64'd0);
`else
      wait_result(1, 0, "mul_off");
      chk("mul_off_res", 64'(bus.result), 64'd0);
      chk("mul_off_err", 64'(bus.err), 64'd1);
`endif

      // Illegal opcode
      issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
      wait_result(1, 0, "illegal");
      chk("illegal_res", 64'(bus.result), 64'd0);
      chk("illegal_flags", 64'({bus.carry_out, bus.overflow, bus.zero, bus.err}), 64'b0001);

      // Back-to-back issue at one op per cycle
      issue(ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b1);
      t0 = t_acc;
      issue(ALU_OR,  32'h1234_0000, 32'h0000_5678, 1'b0, 1'b1);
      issue(ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, 1'b1);
      issue(ALU_SLL, 32'h0000_0001, 32'hFFFF_FFE1, 1'b0, 1'b1);
      issue(ALU_SRL, 32'h8000_0000, 32'h0000_001F, 1'b0, 1'b1);
      issue(ALU_ADD, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b1);
      chk("throughput", 64'((t_acc - t0) / 10), 64'd5);
      wait_result(1, 0, "b2b_last");
      chk("b2b_last_res", 64'(bus.result), 64'd3);

      // Back-pressure: result held, new op refused until out_ready
      issue(ALU_XOR, 32'h0000_FFFF, 32'h00FF_00FF, 1'b0, 1'b0);
      t0 = t_acc;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.alu_op   = ALU_OR;
         bus.a        = 32'h0F00_0000;
         bus.b        = 32'h0000_00F0;
         bus.in_valid = 1'b1;
         #1;
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_result", 64'(bus.result), 64'h00FF_FF00);
      end
      issue(ALU_OR, 32'h0F00_0000, 32'h0000_00F0, 1'b0, 1'b1);
      chk("bp_accept_edge", 64'((t_acc - t0) / 10), 64'd4);
      wait_result(1, 0, "bp_or");
      chk("bp_or_res", 64'(bus.result), 64'h0F00_00F0);

      // Reset in the middle of an operation
`ifdef ALU_SEQ_MUL_EN
      issue(ALU_MUL, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b1);
`else
      issue(ALU_ADD, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
`endif
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      #1;
`ifdef ALU_SEQ_MUL_EN
      chk("mid_mul_busy", 64'({bus.in_ready, bus.out_valid}), 64'b00);
`else
      chk("mid_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("mid_hold_res", 64'(bus.result), 64'h30);
`endif
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_result", 64'(bus.result), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      issue(ALU_ADD, 32'd2, 32'd3, 1'b0, 1'b1);
      wait_result(1, 0, "post_rst_add");
      chk("post_rst_add_res", 64'(bus.result), 64'd5);

      repeat (3) @(negedge clk);
      #3;
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
